// File: rtl/tournament_chooser.sv
// Tournament chooser: a table of saturating choice counters picks between the global and local predictors.
// Optional per-choice selection statistics are enabled by defining TOURN_STATS_EN.
module tournament_chooser #(
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 2**(CTR_W-1)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ready_o,
    input  logic             pred_v_i,
    input  logic [IDX_W-1:0] pred_idx_i,
    input  logic             global_in,
    input  logic             Local_in,
    output logic             pred_v_o,
    output logic             branch_predict,
    output logic             pred_use_global_o,
    input  logic             upd_v_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_global_correct_i,
    input  logic             upd_local_correct_i
`ifdef TOURN_STATS_EN
    ,
    output logic [31:0]      stat_global_sel_o,
    output logic [31:0]      stat_local_sel_o
`endif
);

    localparam int DEPTH = 2**IDX_W;
    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(CTR_INIT);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] init_ptr;
    logic [CTR_W-1:0] ctr_table [DEPTH];
    logic [CTR_W-1:0] rd_ctr;
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_next;
    logic             choice;

    // Counter MSB set means "trust global"; agreement makes the choice irrelevant.
    always_comb begin
        rd_ctr = ctr_table[pred_idx_i];
        if (global_in == Local_in)
            choice = global_in;
        else if (rd_ctr[CTR_W-1])
            choice = global_in;
        else
            choice = Local_in;
    end

    always_comb begin
        upd_cur  = ctr_table[upd_idx_i];
        upd_next = upd_cur;
        if (upd_global_correct_i && !upd_local_correct_i && upd_cur != CTR_MAX)
            upd_next = upd_cur + 1'b1;
        else if (upd_local_correct_i && !upd_global_correct_i && upd_cur != '0)
            upd_next = upd_cur - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_INIT;
            init_ptr          <= '0;
            ready_o           <= 1'b0;
            pred_v_o          <= 1'b0;
            branch_predict    <= 1'b0;
            pred_use_global_o <= 1'b0;
        end else begin
            pred_v_o <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == {IDX_W{1'b1}}) begin
                        state   <= ST_READY;
                        ready_o <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (pred_v_i) begin
                        pred_v_o          <= 1'b1;
                        pred_use_global_o <= rd_ctr[CTR_W-1];
                        branch_predict    <= choice;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Lookups read the pre-write value, so a same-cycle update is seen one cycle later.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT)
                ctr_table[init_ptr] <= INIT_VAL;
            else if (upd_v_i)
                ctr_table[upd_idx_i] <= upd_next;
        end
    end

`ifdef TOURN_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_global_sel_o <= '0;
            stat_local_sel_o  <= '0;
        end else if (state == ST_READY && pred_v_i && global_in != Local_in) begin
            if (rd_ctr[CTR_W-1]) begin
                if (stat_global_sel_o != 32'hFFFF_FFFF)
                    stat_global_sel_o <= stat_global_sel_o + 32'd1;
            end else begin
                if (stat_local_sel_o != 32'hFFFF_FFFF)
                    stat_local_sel_o <= stat_local_sel_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tournament_chooser.sv
// Scoreboard bench for tournament_chooser (IDX_W=4): directed lookups/updates with hand-computed predictions.
module tb_tournament_chooser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ready_o;
    logic       pred_v_i;
    logic [3:0] pred_idx_i;
    logic       global_in;
    logic       Local_in;
    logic       pred_v_o;
    logic       branch_predict;
    logic       pred_use_global_o;
    logic       upd_v_i;
    logic [3:0] upd_idx_i;
    logic       upd_global_correct_i;
    logic       upd_local_correct_i;
`ifdef TOURN_STATS_EN
    logic [31:0] stat_global_sel_o;
    logic [31:0] stat_local_sel_o;
`endif

    int checks = 0;
    int failures = 0;
    logic [1:0] sb [$];

    tournament_chooser #(.IDX_W(4), .CTR_W(2), .CTR_INIT(2)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ready_o              (ready_o),
        .pred_v_i             (pred_v_i),
        .pred_idx_i           (pred_idx_i),
        .global_in            (global_in),
        .Local_in             (Local_in),
        .pred_v_o             (pred_v_o),
        .branch_predict       (branch_predict),
        .pred_use_global_o    (pred_use_global_o),
        .upd_v_i              (upd_v_i),
        .upd_idx_i            (upd_idx_i),
        .upd_global_correct_i (upd_global_correct_i),
        .upd_local_correct_i  (upd_local_correct_i)
`ifdef TOURN_STATS_EN
        ,
        .stat_global_sel_o    (stat_global_sel_o),
        .stat_local_sel_o     (stat_local_sel_o)
`endif
    );

    always #5 clk = ~clk;

    // Each expected prediction must appear exactly one edge after it was pushed.
    always @(posedge clk) begin
        logic [1:0] exp_v;
        #1;
        if (pred_v_o === 1'b1 || sb.size() > 0) begin
            checks++;
            if (pred_v_o !== 1'b1) begin
                failures++;
                exp_v = sb.pop_front();
                $display("[TB] FAIL pred_missing: pred_v_o=%b required=1", pred_v_o);
            end else if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL pred_unexpected: pred_v_o=1 required=0");
            end else begin
                exp_v = sb.pop_front();
                if ({branch_predict, pred_use_global_o} !== exp_v) begin
                    failures++;
                    $display("[TB] FAIL pred_value: {branch_predict,use_global}=%b required=%b",
                             {branch_predict, pred_use_global_o}, exp_v);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic pv, input logic [3:0] idx,
                                 input logic g, input logic l, input logic uv,
                                 input logic [3:0] uidx, input logic gc, input logic lc,
                                 input logic expv, input logic expbp, input logic expug);
        rst_n                = rst;
        pred_v_i             = pv;
        pred_idx_i           = idx;
        global_in            = g;
        Local_in             = l;
        upd_v_i              = uv;
        upd_idx_i            = uidx;
        upd_global_correct_i = gc;
        upd_local_correct_i  = lc;
        if (expv)
            sb.push_back({expbp, expug});
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic lookup(input logic [3:0] idx, input logic g, input logic l,
                          input logic bp, input logic ug);
        applyStimulus(1'b1, 1'b1, idx, g, l, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, bp, ug);
    endtask

    task automatic update(input logic [3:0] idx, input logic gc, input logic lc);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, idx, gc, lc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Release reset with lookups and updates pending; ready must rise after exactly 16 edges.
    task automatic runInit(input string tag);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput({tag, "_ready"}, {31'd0, ready_o}, (i == 16) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("rst_pred_v", {31'd0, pred_v_o}, 32'd0);
        checkOutput("rst_branch", {31'd0, branch_predict}, 32'd0);
        checkOutput("rst_use_global", {31'd0, pred_use_global_o}, 32'd0);

        runInit("init");

        // Counter at 2 despite the update offered during init.
        lookup(4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        checkOutput("hold_branch_1", {31'd0, branch_predict}, 32'd1);

        // Local-correct training saturates at 0.
        update(4'd3, 1'b0, 1'b1);
        update(4'd3, 1'b0, 1'b1);
        update(4'd3, 1'b0, 1'b1);
        lookup(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        checkOutput("hold_branch_0", {31'd0, branch_predict}, 32'd0);

        // Global-correct training saturates at 3, then one step down stays global.
        for (int i = 0; i < 4; i++) update(4'd3, 1'b1, 1'b0);
        lookup(4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        update(4'd3, 1'b0, 1'b1);
        lookup(4'd3, 1'b1, 1'b0, 1'b1, 1'b1);

        // Agreement at ctr=0, then neutral updates leave ctr=1 unchanged.
        update(4'd7, 1'b0, 1'b1);
        update(4'd7, 1'b0, 1'b1);
        lookup(4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        lookup(4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        update(4'd7, 1'b1, 1'b0);
        update(4'd7, 1'b1, 1'b1);
        update(4'd7, 1'b0, 1'b0);
        lookup(4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup(4'd7, 1'b0, 1'b1, 1'b1, 1'b0);

        // Same-cycle lookup and local-correct update on idx 5, then back-to-back re-read.
        applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        lookup(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a lookup stream.
        lookup(4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        lookup(4'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_pred_v", {31'd0, pred_v_o}, 32'd0);
        checkOutput("midrst_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("midrst_branch", {31'd0, branch_predict}, 32'd0);
`ifdef TOURN_STATS_EN
        checkOutput("stat_global_clr", stat_global_sel_o, 32'd0);
        checkOutput("stat_local_clr", stat_local_sel_o, 32'd0);
`endif

        runInit("reinit");

        lookup(4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        lookup(4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        update(4'd3, 1'b0, 1'b1);
        lookup(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TOURN_STATS_EN
        idle();
        checkOutput("stat_global", stat_global_sel_o, 32'd2);
        checkOutput("stat_local", stat_local_sel_o, 32'd1);
`endif

        idle();
        idle();
        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
